riscv_mem_port_arbiter: RTL and testbench



---
 rtl/riscv_pkg.sv | 35 +++
 rtl/riscv_rr_arbiter2.sv | 35 +++
 rtl/riscv_mem_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_riscv_mem_port_arbiter.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the memory-port arbiter: FSM states, grant encoding and
// the round-robin pick rule used by the two-input arbiter.
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2,
        DONE = 2'd3
    } mem_arb_state_t;

    typedef enum logic {
        GRANT_IF   = 1'b0,
        GRANT_DATA = 1'b1
    } mem_arb_grant_t;

    // Contention goes to whoever was not served last; otherwise the lone requester wins.
    function automatic mem_arb_grant_t rr_pick(input logic if_req, input logic data_req,
                                               input mem_arb_grant_t last);
        mem_arb_grant_t pick;
        if (if_req && data_req) begin
            if (last == GRANT_IF) begin
                pick = GRANT_DATA;
            end else begin
                pick = GRANT_IF;
            end
        end else if (if_req) begin
            pick = GRANT_IF;
        end else begin
            pick = GRANT_DATA;
        end
        return pick;
    endfunction

endpackage

// File: rtl/riscv_rr_arbiter2.sv
// Two-input round-robin arbiter. The last-served register only moves on the
// update strobe, so a grant stays fair across multi-cycle transactions.
module riscv_rr_arbiter2
    import riscv_pkg::*;
(
    input  logic           clk,
    input  logic           nreset,
    input  logic           req_if,
    input  logic           req_data,
    input  logic           update,
    input  mem_arb_grant_t served,
    output logic           grant_valid,
    output mem_arb_grant_t grant
);

    mem_arb_grant_t last_grant_r;

    // Combinational pick from the current requests and the last-served side.
    always_comb begin
        grant_valid = req_if | req_data;
        grant       = rr_pick(req_if, req_data, last_grant_r);
    end

    // Last-served register; resets to data so fetch wins the first contention.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            last_grant_r <= GRANT_DATA;
        end else if (update) begin
            last_grant_r <= served;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

endmodule

// File: rtl/riscv_mem_port_arbiter.sv
// Shares the single downstream memory port between instruction fetch and
// load/store, one transaction at a time, sequenced IDLE -> REQ -> RSP -> DONE.
module riscv_mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_WIDTH  = 64,
    parameter int DATA_WIDTH  = 64,
    parameter int INSTR_WIDTH = 32,
    parameter int STRB_WIDTH  = DATA_WIDTH / 8
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   enable,
    input  logic                   i_if_req,
    input  logic [ADDR_WIDTH-1:0]  i_if_addr,
    input  logic                   i_if_flush,
    output logic                   o_if_valid,
    output logic [INSTR_WIDTH-1:0] o_if_instr,
    input  logic [ADDR_WIDTH-1:0]  i_d_addr,
    input  logic                   i_d_wr_valid,
    input  logic [DATA_WIDTH-1:0]  i_d_wr_data,
    input  logic [STRB_WIDTH-1:0]  i_d_wr_strb,
    output logic                   o_d_wr_ready,
    input  logic                   i_d_rd_ready,
    output logic                   o_d_rd_valid,
    output logic [DATA_WIDTH-1:0]  o_d_rd_data,
    output logic                   o_d_err,
    output logic                   o_req_valid,
    output logic                   o_req_write,
    output logic [ADDR_WIDTH-1:0]  o_req_addr,
    output logic [DATA_WIDTH-1:0]  o_req_wdata,
    output logic [STRB_WIDTH-1:0]  o_req_strb,
    input  logic                   i_req_ready,
    input  logic                   i_rsp_valid,
    input  logic [DATA_WIDTH-1:0]  i_rsp_data,
    input  logic                   i_rsp_err,
    output logic                   o_rsp_ready,
    output logic                   o_busy
);

    mem_arb_state_t         state_r;
    mem_arb_grant_t         gnt_r;
    mem_arb_grant_t         pick_s;
    logic                   pick_valid_s;
    logic                   data_req_s;
    logic                   arb_update_s;
    logic                   flush_hit_s;
    logic                   drop_fetch_r;
    logic [INSTR_WIDTH-1:0] instr_sel_s;

    // Request summary, arbiter update strobe and flush qualification.
    always_comb begin
        data_req_s   = i_d_wr_valid | i_d_rd_ready;
        arb_update_s = (state_r == DONE);
        flush_hit_s  = (gnt_r == GRANT_IF) && i_if_flush;
    end

    riscv_rr_arbiter2 u_rr (
        .clk         (clk),
        .nreset      (nreset),
        .req_if      (i_if_req),
        .req_data    (data_req_s),
        .update      (arb_update_s),
        .served      (gnt_r),
        .grant_valid (pick_valid_s),
        .grant       (pick_s)
    );

    // A 64-bit beat carries two instructions; address bit 2 picks the upper word.
    always_comb begin
        if ((DATA_WIDTH == 64) && o_req_addr[2]) begin
            instr_sel_s = INSTR_WIDTH'(i_rsp_data >> 32'd32);
        end else begin
            instr_sel_s = INSTR_WIDTH'(i_rsp_data);
        end
    end

    assign o_req_valid = (state_r == REQ);
    assign o_rsp_ready = (state_r == RSP);
    assign o_busy      = (state_r != IDLE);

    // Transaction FSM with field latches, response latches and completion pulses.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_r      <= IDLE;
            gnt_r        <= GRANT_IF;
            drop_fetch_r <= 1'b0;
            o_req_write  <= 1'b0;
            o_req_addr   <= '0;
            o_req_wdata  <= '0;
            o_req_strb   <= '0;
            o_if_valid   <= 1'b0;
            o_if_instr   <= '0;
            o_d_wr_ready <= 1'b0;
            o_d_rd_valid <= 1'b0;
            o_d_rd_data  <= '0;
            o_d_err      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (enable && pick_valid_s) begin
                        gnt_r   <= pick_s;
                        state_r <= REQ;
                        if (pick_s == GRANT_IF) begin
                            o_req_write <= 1'b0;
                            o_req_addr  <= i_if_addr;
                            o_req_wdata <= '0;
                            o_req_strb  <= '0;
                        end else begin
                            // Store outranks load when both are held on the data side.
                            o_req_write <= i_d_wr_valid;
                            o_req_addr  <= i_d_addr;
                            o_req_wdata <= i_d_wr_valid ? i_d_wr_data : '0;
                            o_req_strb  <= i_d_wr_valid ? i_d_wr_strb : '0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (flush_hit_s) begin
                        drop_fetch_r <= 1'b1;
                    end else begin
                        drop_fetch_r <= drop_fetch_r;
                    end
                    if (i_req_ready) begin
                        state_r <= RSP;
                    end else begin
                        state_r <= REQ;
                    end
                end
                RSP: begin
                    if (flush_hit_s) begin
                        drop_fetch_r <= 1'b1;
                    end else begin
                        drop_fetch_r <= drop_fetch_r;
                    end
                    if (i_rsp_valid) begin
                        state_r <= DONE;
                        if (gnt_r == GRANT_IF) begin
                            // Fetch errors are swallowed; a flushed fetch completes silently.
                            o_if_valid <= ~(drop_fetch_r | flush_hit_s);
                            o_if_instr <= instr_sel_s;
                        end else begin
                            o_d_wr_ready <= o_req_write;
                            o_d_rd_valid <= ~o_req_write;
                            o_d_err      <= i_rsp_err;
                            if (!o_req_write) begin
                                o_d_rd_data <= i_rsp_data;
                            end else begin
                                o_d_rd_data <= o_d_rd_data;
                            end
                        end
                    end else begin
                        state_r <= RSP;
                    end
                end
                DONE: begin
                    o_if_valid   <= 1'b0;
                    o_d_wr_ready <= 1'b0;
                    o_d_rd_valid <= 1'b0;
                    o_d_err      <= 1'b0;
                    drop_fetch_r <= 1'b0;
                    state_r      <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_port_arbiter.sv
// Randomized bench: a behavioural arbitration model predicts each grant, a
// memory responder pushes expected completions, and a monitor pops and checks them.
module tb_riscv_mem_port_arbiter;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        enable = 1'b0;
    logic        i_if_req = 1'b0;
    logic [63:0] i_if_addr = 64'd0;
    logic        i_if_flush = 1'b0;
    logic        o_if_valid;
    logic [31:0] o_if_instr;
    logic [63:0] i_d_addr = 64'd0;
    logic        i_d_wr_valid = 1'b0;
    logic [63:0] i_d_wr_data = 64'd0;
    logic [7:0]  i_d_wr_strb = 8'd0;
    logic        o_d_wr_ready;
    logic        i_d_rd_ready = 1'b0;
    logic        o_d_rd_valid;
    logic [63:0] o_d_rd_data;
    logic        o_d_err;
    logic        o_req_valid;
    logic        o_req_write;
    logic [63:0] o_req_addr;
    logic [63:0] o_req_wdata;
    logic [7:0]  o_req_strb;
    logic        i_req_ready = 1'b0;
    logic        i_rsp_valid = 1'b0;
    logic [63:0] i_rsp_data = 64'd0;
    logic        i_rsp_err = 1'b0;
    logic        o_rsp_ready;
    logic        o_busy;

    always #5 clk = ~clk;

    riscv_mem_port_arbiter dut (
        .clk(clk), .nreset(nreset), .enable(enable),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_if_flush(i_if_flush),
        .o_if_valid(o_if_valid), .o_if_instr(o_if_instr),
        .i_d_addr(i_d_addr), .i_d_wr_valid(i_d_wr_valid), .i_d_wr_data(i_d_wr_data),
        .i_d_wr_strb(i_d_wr_strb), .o_d_wr_ready(o_d_wr_ready),
        .i_d_rd_ready(i_d_rd_ready), .o_d_rd_valid(o_d_rd_valid), .o_d_rd_data(o_d_rd_data),
        .o_d_err(o_d_err),
        .o_req_valid(o_req_valid), .o_req_write(o_req_write), .o_req_addr(o_req_addr),
        .o_req_wdata(o_req_wdata), .o_req_strb(o_req_strb), .i_req_ready(i_req_ready),
        .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
        .o_rsp_ready(o_rsp_ready), .o_busy(o_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Requester inputs as they stood at the most recent rising edge.
    logic        snap_en, snap_if_req, snap_wr, snap_rd;
    logic [63:0] snap_if_addr, snap_d_addr, snap_wdata;
    logic [7:0]  snap_strb;
    always @(posedge clk) begin
        snap_en      <= enable;
        snap_if_req  <= i_if_req;
        snap_wr      <= i_d_wr_valid;
        snap_rd      <= i_d_rd_ready;
        snap_if_addr <= i_if_addr;
        snap_d_addr  <= i_d_addr;
        snap_wdata   <= i_d_wr_data;
        snap_strb    <= i_d_wr_strb;
    end

    // Responder configuration: negative means randomize.
    int          cfg_rdy = -1;
    int          cfg_rsp = -1;
    int          cfg_err = -1;
    bit          cfg_fix = 1'b0;
    logic [63:0] cfg_data = 64'd0;
    bit          flush_flag = 1'b0;

    typedef struct {
        logic [3:0]  pat;   // {if_valid, wr_ready, rd_valid, err}
        logic [63:0] val;
    } cpl_t;
    cpl_t exp_q[$];

    mem_arb_grant_t m_last = GRANT_DATA;

    task automatic serve();
        mem_arb_grant_t g;
        logic        wr;
        logic [63:0] a, wd, rdata;
        logic [7:0]  st;
        logic        err;
        int          rd, sd;
        cpl_t        c;
        chk("grant_while_enabled", {63'd0, snap_en}, 64'd1);
        chk("grant_has_requester", {63'd0, snap_if_req | snap_wr | snap_rd}, 64'd1);
        if (snap_if_req && (snap_wr || snap_rd))
            g = (m_last == GRANT_IF) ? GRANT_DATA : GRANT_IF;
        else
            g = snap_if_req ? GRANT_IF : GRANT_DATA;
        m_last = g;
        wr = (g == GRANT_DATA) && snap_wr;
        a  = (g == GRANT_IF) ? snap_if_addr : snap_d_addr;
        wd = snap_wdata;
        st = snap_strb;
        chk("req_write", {63'd0, o_req_write}, {63'd0, wr});
        chk("req_addr", o_req_addr, a);
        if (wr) begin
            chk("req_wdata", o_req_wdata, wd);
            chk("req_strb", {56'd0, o_req_strb}, {56'd0, st});
        end
        rd = (cfg_rdy < 0) ? int'($urandom_range(0, 4)) : cfg_rdy;
        sd = (cfg_rsp < 0) ? int'($urandom_range(0, 5)) : cfg_rsp;
        for (int k = 0; k < rd; k++) begin
            @(negedge clk);
            if (!nreset) return;
            chk("req_hold", {61'd0, o_req_valid, o_req_write, o_busy}, {61'd0, 1'b1, wr, 1'b1});
            chk("req_addr_hold", o_req_addr, a);
            if (wr) chk("req_wdata_hold", o_req_wdata, wd);
        end
        i_req_ready = 1'b1;
        @(negedge clk);
        i_req_ready = 1'b0;
        if (!nreset) return;
        chk("rsp_phase", {62'd0, o_rsp_ready, o_req_valid}, {62'd0, 1'b1, 1'b0});
        for (int k = 0; k < sd; k++) begin
            @(negedge clk);
            if (!nreset) return;
            chk("rsp_ready_hold", {62'd0, o_rsp_ready, o_busy}, {62'd0, 1'b1, 1'b1});
        end
        rdata = cfg_fix ? cfg_data : {$urandom, $urandom};
        err   = (cfg_err < 0) ? 1'($urandom_range(0, 1)) : 1'(cfg_err);
        i_rsp_valid = 1'b1;
        i_rsp_data  = rdata;
        i_rsp_err   = err;
        if (g == GRANT_IF) begin
            if (!flush_flag) begin
                c.pat = 4'b1000;
                c.val = a[2] ? {32'd0, rdata[63:32]} : {32'd0, rdata[31:0]};
                exp_q.push_back(c);
            end
        end else begin
            c.pat = wr ? {3'b010, err} : {3'b001, err};
            c.val = rdata;
            exp_q.push_back(c);
        end
        @(negedge clk);
        i_rsp_valid = 1'b0;
        i_rsp_err   = 1'b0;
    endtask

    // Memory responder.
    initial begin : responder
        forever begin
            @(negedge clk);
            if (!nreset) m_last = GRANT_DATA;
            else if (o_req_valid) serve();
        end
    end

    int if_cnt = 0, wr_cnt = 0, rd_cnt = 0, reqv_cycles = 0;

    // Completion monitor.
    initial begin : monitor
        cpl_t c;
        forever begin
            @(negedge clk);
            if (o_req_valid) reqv_cycles++;
            if (o_if_valid || o_d_wr_ready || o_d_rd_valid || o_d_err) begin
                if (o_if_valid) if_cnt++;
                if (o_d_wr_ready) wr_cnt++;
                if (o_d_rd_valid) rd_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_completion",
                        {60'd0, o_if_valid, o_d_wr_ready, o_d_rd_valid, o_d_err}, 64'd0);
                end else begin
                    c = exp_q.pop_front();
                    chk("cpl_kind", {60'd0, o_if_valid, o_d_wr_ready, o_d_rd_valid, o_d_err},
                        {60'd0, c.pat});
                    if (c.pat[3]) chk("if_instr", {32'd0, o_if_instr}, c.val);
                    if (c.pat[1]) chk("rd_data", o_d_rd_data, c.val);
                end
            end
        end
    end

    task automatic fetch_txn(input logic [63:0] a);
        int n = 0;
        i_if_req  = 1'b1;
        i_if_addr = a;
        do begin @(negedge clk); n++; end while (!o_if_valid && n < 400);
        if (!o_if_valid) chk("fetch_timeout", 64'd0, 64'd1);
        i_if_req = 1'b0;
    endtask

    task automatic data_txn(input bit wr, input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] s);
        int n = 0;
        i_d_addr    = a;
        i_d_wr_data = d;
        i_d_wr_strb = s;
        if (wr) i_d_wr_valid = 1'b1;
        else    i_d_rd_ready = 1'b1;
        do begin @(negedge clk); n++; end
        while (!(wr ? o_d_wr_ready : o_d_rd_valid) && n < 400);
        if (!(wr ? o_d_wr_ready : o_d_rd_valid)) chk("data_timeout", 64'd0, 64'd1);
        i_d_wr_valid = 1'b0;
        i_d_rd_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 nreset = 1'b0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (o_busy && n < 100) begin @(negedge clk); n++; end
        chk(name, {63'd0, o_busy}, 64'd0);
    endtask

    initial begin : main
        int n, c0;
        // Reset state
        repeat (2) @(negedge clk);
        chk("reset_ctrl", {56'd0, o_req_valid, o_rsp_ready, o_busy, o_if_valid,
                           o_d_wr_ready, o_d_rd_valid, o_d_err, o_req_write}, 64'd0);
        chk("reset_addr", o_req_addr, 64'd0);
        chk("reset_data", o_d_rd_data | o_req_wdata | {32'd0, o_if_instr} | {56'd0, o_req_strb}, 64'd0);
        nreset = 1'b1;
        enable = 1'b1;
        @(negedge clk);

        // Zero-wait fetch with cycle-exact timing
        cfg_rdy = 0; cfg_rsp = 0; cfg_err = 0; cfg_fix = 1'b1;
        cfg_data = 64'hAAAA_BBBB_1111_2222;
        i_if_req = 1'b1; i_if_addr = 64'h1004;
        @(negedge clk);
        chk("t1_req_valid_c1", {63'd0, o_req_valid}, 64'd1);
        @(negedge clk);
        chk("t1_rsp_ready_c2", {63'd0, o_rsp_ready}, 64'd1);
        @(negedge clk);
        chk("t1_if_valid_c3", {63'd0, o_if_valid}, 64'd1);
        chk("t1_instr", {32'd0, o_if_instr}, 64'h0000_0000_AAAA_BBBB);
        i_if_req = 1'b0;
        @(negedge clk);
        chk("t1_idle_c4", {62'd0, o_if_valid, o_busy}, 64'd0);
        cfg_fix = 1'b0; cfg_rdy = -1; cfg_rsp = -1; cfg_err = -1;

        // Fetch and store pending together straight out of reset
        do_reset();
        c0 = wr_cnt;
        fork
            fetch_txn(64'h2000);
            data_txn(1'b1, 64'h3000, 64'h55, 8'h0F);
        join
        chk("t2_wr_pulses", 64'(wr_cnt - c0), 64'd1);

        // Store and load held together: store first
        c0 = rd_cnt;
        i_d_addr = 64'h4000; i_d_wr_data = 64'h1234; i_d_wr_strb = 8'hFF;
        i_d_wr_valid = 1'b1; i_d_rd_ready = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_d_wr_ready && n < 100);
        chk("t3_store_done", {63'd0, o_d_wr_ready}, 64'd1);
        chk("t3_no_load_yet", 64'(rd_cnt - c0), 64'd0);
        i_d_wr_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_d_rd_valid && n < 100);
        chk("t3_load_done", {63'd0, o_d_rd_valid}, 64'd1);
        i_d_rd_ready = 1'b0;

        // Continuous fetch and load: alternation is checked by the grant model
        fork
            for (int i = 0; i < 6; i++) fetch_txn(64'($urandom_range(0, 4095)) << 2);
            for (int i = 0; i < 6; i++) data_txn(1'b0, 64'h8000 + 64'(i * 8), 64'd0, 8'd0);
        join

        // Backpressure on both phases
        cfg_rdy = 5; cfg_rsp = 7;
        fetch_txn(64'h5008);
        data_txn(1'b1, 64'h6000, 64'hDEAD_BEEF_0000_0001, 8'hA5);
        cfg_rdy = -1; cfg_rsp = -1;

        // Flush during RSP: bus completes, no fetch pulse
        cfg_rdy = 0; cfg_rsp = 3;
        wait_idle("t5_idle_before");
        c0 = if_cnt;
        i_if_req = 1'b1; i_if_addr = 64'h7000;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_rsp_ready && n < 50);
        chk("t5_reach_rsp", {63'd0, o_rsp_ready}, 64'd1);
        flush_flag = 1'b1;
        i_if_flush = 1'b1; i_if_req = 1'b0;
        @(negedge clk);
        i_if_flush = 1'b0;
        wait_idle("t5_idle_after");
        repeat (2) @(negedge clk);
        chk("t5_no_if_valid", 64'(if_cnt - c0), 64'd0);
        flush_flag = 1'b0;
        cfg_rsp = -1;
        fetch_txn(64'h7004);

        // Load error, then enable low at grant time
        cfg_err = 1;
        data_txn(1'b0, 64'h9000, 64'd0, 8'd0);
        enable = 1'b0;
        c0 = reqv_cycles;
        i_d_addr = 64'h9008; i_d_rd_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("t6_no_grant_disabled", 64'(reqv_cycles - c0), 64'd0);
        chk("t6_not_busy", {63'd0, o_busy}, 64'd0);
        enable = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_d_rd_valid && n < 100);
        chk("t6_load_err_done", {62'd0, o_d_rd_valid, o_d_err}, 64'd3);
        i_d_rd_ready = 1'b0;
        cfg_err = -1;

        // Random mixed traffic with enable toggling
        fork
            for (int i = 0; i < 15; i++) begin
                fetch_txn(64'($urandom_range(0, 4095)) << 2);
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            for (int i = 0; i < 15; i++) begin
                data_txn(1'($urandom_range(0, 1)), 64'($urandom_range(0, 4095)) << 3,
                         {$urandom, $urandom}, 8'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            begin
                repeat (60) begin @(negedge clk); enable = 1'($urandom_range(0, 3) != 0); end
                enable = 1'b1;
            end
        join

        // Reset asserted during RSP
        cfg_rdy = 0; cfg_rsp = 10;
        wait_idle("t7_idle_before");
        i_if_req = 1'b1; i_if_addr = 64'hA000;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_rsp_ready && n < 50);
        chk("t7_reach_rsp", {63'd0, o_rsp_ready}, 64'd1);
        i_if_req = 1'b0;
        #2 nreset = 1'b0;
        #1;
        chk("t7_reset_ctrl", {57'd0, o_req_valid, o_rsp_ready, o_busy, o_if_valid,
                              o_d_wr_ready, o_d_rd_valid, o_d_err}, 64'd0);
        chk("t7_reset_addr", o_req_addr, 64'd0);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        cfg_rsp = -1;
        fetch_txn(64'hB004);

        repeat (5) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
